// File: rtl/modulo_mem_dados_be_if.sv
// Request/response bundle for the byte-addressable data memory.
// The processor side (master) drives requests and err_clear; the memory
// side (slave) returns one response per accepted request plus the sticky
// error flag.
interface modulo_mem_dados_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  err_clear;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  err_sticky;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, err_clear,
        input  rsp_valid, rsp_rdata, rsp_err, err_sticky
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, err_clear,
        output rsp_valid, rsp_rdata, rsp_err, err_sticky
    );
endinterface

// File: rtl/modulo_mem_dados_be.sv
// Byte-addressable data memory for the load/store path.
// One request per cycle, no backpressure. Stores use per-lane byte enables,
// loads are extracted from a registered full-word read and sign/zero
// extended in the response cycle. Misaligned or illegal accesses are
// answered with rsp_err and never touch the array. OUT_REG adds one
// register stage on the response for timing.
module modulo_mem_dados_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int OUT_REG    = 0
) (
    input logic                    clock,
    input logic                    reset_n,
    modulo_mem_dados_be_if.slave   bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int IW    = ADDR_WIDTH - LB;
    localparam int DEPTH = 2 ** IW;
    // Doubleword accesses only exist when a memory word is 64 bits wide.
    localparam bit HAS_DOUBLE = (DATA_WIDTH == 64);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IW-1:0]         req_idx;
    logic [LB-1:0]         req_off;
    logic [2:0]            req_off3;
    logic [3:0]            req_nbytes;
    logic                  req_misalign;
    logic                  req_illegal;
    logic                  req_err;
    logic [NB-1:0]         lane_be;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;

    assign req_idx    = bus.req_addr[ADDR_WIDTH-1:LB];
    assign req_off    = bus.req_addr[LB-1:0];
    // Offset widened to 3 bits so the alignment checks read the same for
    // both word widths (the missing bit of a 32-bit build is simply 0).
    assign req_off3   = 3'(req_off);
    assign req_nbytes = 4'd1 << bus.req_size;

    // Alignment check: every access must start on a multiple of its size.
    always_comb begin
        req_misalign = 1'b0;
        case (bus.req_size)
            2'b00:   req_misalign = 1'b0;
            2'b01:   req_misalign = req_off3[0];
            2'b10:   req_misalign = |req_off3[1:0];
            default: req_misalign = |req_off3;
        endcase
    end

    assign req_illegal = (bus.req_size == 2'b11) && !HAS_DOUBLE;
    assign req_err     = req_misalign | req_illegal;

    // A lane is enabled when it falls inside [offset, offset + nbytes).
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_be[gi] = (gi >= int'(req_off)) &&
                                 (gi <  int'(req_off) + int'(req_nbytes));
        end
    endgenerate

    // Errored stores are dropped here, so the array is never written by them.
    assign wr_en   = bus.req_valid & bus.req_we & ~req_err;
    assign wr_be   = lane_be & {NB{wr_en}};
    // Right-aligned store data moved up to its lane position.
    assign wr_data = bus.req_wdata << {req_off, 3'b000};

    // ------------------------------------------------------------------
    // Storage: byte-lane writes plus registered full-word read
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word_reg;

    // Array write with per-byte enables and registered load read; no reset
    // so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                mem[req_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (bus.req_valid && !bus.req_we) begin
            rd_word_reg <= mem[req_idx];
        end
    end

    // ------------------------------------------------------------------
    // Request attributes travelling alongside the RAM read
    // ------------------------------------------------------------------
    logic          s1_valid_reg;
    logic          s1_we_reg;
    logic          s1_err_reg;
    logic          s1_uns_reg;
    logic [1:0]    s1_size_reg;
    logic [LB-1:0] s1_off_reg;

    // Pipeline the attributes needed to shape the response one cycle later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_we_reg    <= 1'b0;
            s1_err_reg   <= 1'b0;
            s1_uns_reg   <= 1'b0;
            s1_size_reg  <= 2'b00;
            s1_off_reg   <= '0;
        end else begin
            s1_valid_reg <= bus.req_valid;
            s1_we_reg    <= bus.req_we;
            s1_err_reg   <= req_err;
            s1_uns_reg   <= bus.req_unsigned;
            s1_size_reg  <= bus.req_size;
            s1_off_reg   <= req_off;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [6:0]            ld_nbits;
    logic [DATA_WIDTH-1:0] ld_mask;
    logic [DATA_WIDTH-1:0] ld_top;
    logic                  ld_sign;
    logic [DATA_WIDTH-1:0] ld_fill;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  rsp_valid_next;
    logic                  rsp_err_next;
    logic [DATA_WIDTH-1:0] rsp_rdata_next;

    // Shift the accessed field down, mask it, and extend from its MSB.
    // A field as wide as the word shifts the all-ones pattern out
    // completely, which leaves the mask at all ones.
    always_comb begin
        ld_shifted = rd_word_reg >> {s1_off_reg, 3'b000};
        ld_nbits   = 7'd8 << s1_size_reg;
        ld_mask    = ~({DATA_WIDTH{1'b1}} << ld_nbits);
        ld_top     = ld_mask & ~(ld_mask >> 1);
        ld_sign    = |(ld_shifted & ld_top);
        ld_fill    = (ld_sign && !s1_uns_reg) ? ~ld_mask : '0;
        ld_data    = (ld_shifted & ld_mask) | ld_fill;

        rsp_valid_next = s1_valid_reg;
        rsp_err_next   = s1_valid_reg & s1_err_reg;
        rsp_rdata_next = '0;
        if (s1_valid_reg && !s1_we_reg && !s1_err_reg) begin
            rsp_rdata_next = ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Response stage (optional extra register)
    // ------------------------------------------------------------------
    logic                  rsp_valid_out;
    logic                  rsp_err_out;
    logic [DATA_WIDTH-1:0] rsp_rdata_out;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rsp_valid_reg;
            logic                  rsp_err_reg;
            logic [DATA_WIDTH-1:0] rsp_rdata_reg;

            // Extra output register: response arrives two cycles after request.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= '0;
                end else begin
                    rsp_valid_reg <= rsp_valid_next;
                    rsp_err_reg   <= rsp_err_next;
                    rsp_rdata_reg <= rsp_rdata_next;
                end
            end

            assign rsp_valid_out = rsp_valid_reg;
            assign rsp_err_out   = rsp_err_reg;
            assign rsp_rdata_out = rsp_rdata_reg;
        end else begin : g_out_direct
            assign rsp_valid_out = rsp_valid_next;
            assign rsp_err_out   = rsp_err_next;
            assign rsp_rdata_out = rsp_rdata_next;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    logic err_sticky_reg;

    // An errored response sets the flag on the edge closing its slot; a set
    // in the same cycle as err_clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky_reg <= 1'b0;
        end else if (rsp_valid_out && rsp_err_out) begin
            err_sticky_reg <= 1'b1;
        end else if (bus.err_clear) begin
            err_sticky_reg <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_out;
    assign bus.rsp_err    = rsp_err_out;
    assign bus.rsp_rdata  = rsp_rdata_out;
    assign bus.err_sticky = err_sticky_reg;
endmodule

// File: tb/tb_modulo_mem_dados_be.sv
// Bench for modulo_mem_dados_be: three instances (32-bit direct, 32-bit with
// output register, 64-bit direct) share one request stream. A byte-array
// model per instance predicts every response; a compare process checks all
// outputs each cycle, and literal expectations pin the model on the
// directed sequence.
module tb_modulo_mem_dados_be;
    logic clk;
    logic reset_n;

    logic        st_valid;
    logic        st_we;
    logic [7:0]  st_addr;
    logic [1:0]  st_size;
    logic        st_uns;
    logic [63:0] st_wdata;
    logic        st_clr;

    int n_checks = 0;
    int n_fail   = 0;

    modulo_mem_dados_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) bus_a ();
    modulo_mem_dados_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) bus_b ();
    modulo_mem_dados_be_if #(.DATA_WIDTH(64), .ADDR_WIDTH(15)) bus_c ();

    modulo_mem_dados_be #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .OUT_REG(0)) dut_a (
        .clock(clk), .reset_n(reset_n), .bus(bus_a));
    modulo_mem_dados_be #(.DATA_WIDTH(32), .ADDR_WIDTH(15), .OUT_REG(1)) dut_b (
        .clock(clk), .reset_n(reset_n), .bus(bus_b));
    modulo_mem_dados_be #(.DATA_WIDTH(64), .ADDR_WIDTH(15), .OUT_REG(0)) dut_c (
        .clock(clk), .reset_n(reset_n), .bus(bus_c));

    assign bus_a.req_valid    = st_valid;
    assign bus_a.req_we       = st_we;
    assign bus_a.req_addr     = {7'b0, st_addr};
    assign bus_a.req_size     = st_size;
    assign bus_a.req_unsigned = st_uns;
    assign bus_a.req_wdata    = st_wdata[31:0];
    assign bus_a.err_clear    = st_clr;

    assign bus_b.req_valid    = st_valid;
    assign bus_b.req_we       = st_we;
    assign bus_b.req_addr     = {7'b0, st_addr};
    assign bus_b.req_size     = st_size;
    assign bus_b.req_unsigned = st_uns;
    assign bus_b.req_wdata    = st_wdata[31:0];
    assign bus_b.err_clear    = st_clr;

    assign bus_c.req_valid    = st_valid;
    assign bus_c.req_we       = st_we;
    assign bus_c.req_addr     = {7'b0, st_addr};
    assign bus_c.req_size     = st_size;
    assign bus_c.req_unsigned = st_uns;
    assign bus_c.req_wdata    = st_wdata;
    assign bus_c.err_clear    = st_clr;

    logic        act_v  [3];
    logic        act_err[3];
    logic        act_st [3];
    logic [63:0] act_rd [3];

    assign act_v[0]   = bus_a.rsp_valid;
    assign act_v[1]   = bus_b.rsp_valid;
    assign act_v[2]   = bus_c.rsp_valid;
    assign act_err[0] = bus_a.rsp_err;
    assign act_err[1] = bus_b.rsp_err;
    assign act_err[2] = bus_c.rsp_err;
    assign act_st[0]  = bus_a.err_sticky;
    assign act_st[1]  = bus_b.err_sticky;
    assign act_st[2]  = bus_c.err_sticky;
    assign act_rd[0]  = {32'h0, bus_a.rsp_rdata};
    assign act_rd[1]  = {32'h0, bus_b.rsp_rdata};
    assign act_rd[2]  = bus_c.rsp_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: bytes of memory, responses as a delay line
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        v;
        logic        err;
        logic        known;
        logic [63:0] rdata;
    } rsp_t;

    rsp_t        cur    [3];
    rsp_t        hold   [3];
    logic        sticky [3];
    logic [7:0]  mb     [3][256];
    bit          kn     [3][256];
    logic [64:0] exp_log[3][$];

    function automatic int width_of(input int k);
        return (k == 2) ? 64 : 32;
    endfunction

    task automatic do_access(input int k, output rsp_t r);
        int          n;
        int          a;
        logic [63:0] val;
        n = 1 << st_size;
        a = int'(st_addr);
        r = '0;
        r.v = 1'b1;
        r.known = 1'b1;
        if ((st_size == 2'b11 && width_of(k) == 32) || (a % n) != 0) begin
            r.err = 1'b1;
        end else if (st_we) begin
            for (int i = 0; i < n; i++) begin
                mb[k][a+i] = st_wdata[8*i +: 8];
                kn[k][a+i] = 1'b1;
            end
        end else begin
            val = '0;
            for (int i = 0; i < n; i++) begin
                val[8*i +: 8] = mb[k][a+i];
                if (!kn[k][a+i]) r.known = 1'b0;
            end
            if (!st_uns && val[8*n-1]) begin
                for (int b = 8*n; b < 64; b++) val[b] = 1'b1;
            end
            if (width_of(k) == 32) val[63:32] = '0;
            r.rdata = val;
        end
        exp_log[k].push_back({r.err, r.rdata});
    endtask

    initial begin
        rsp_t r;
        for (int k = 0; k < 3; k++) begin
            cur[k] = '0; hold[k] = '0; sticky[k] = 1'b0;
            for (int i = 0; i < 256; i++) kn[k][i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) begin
                    cur[k] = '0; hold[k] = '0; sticky[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (cur[k].v && cur[k].err) sticky[k] = 1'b1;
                    else if (st_clr)            sticky[k] = 1'b0;
                    r = '0;
                    if (st_valid) do_access(k, r);
                    if (k == 1) begin
                        cur[k]  = hold[k];
                        hold[k] = r;
                    end else begin
                        cur[k] = r;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d_rsp_valid", k), 64'(act_v[k]), 64'(cur[k].v));
                check($sformatf("dut%0d_err_sticky", k), 64'(act_st[k]), 64'(sticky[k]));
                if (cur[k].v)
                    check($sformatf("dut%0d_rsp_err", k), 64'(act_err[k]), 64'(cur[k].err));
                if (!cur[k].v || cur[k].known)
                    check($sformatf("dut%0d_rsp_rdata", k), act_rd[k], cur[k].rdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input logic we, input logic [7:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input logic clr);
        @(negedge clk);
        st_valid = 1'b1; st_we = we; st_addr = addr; st_size = size;
        st_uns = uns; st_wdata = wdata; st_clr = clr;
        $display("req t=%0t we=%0d addr=0x%02h size=%0d uns=%0d wdata=0x%016h clr=%0d",
                 $time, we, addr, size, uns, wdata, clr);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st_valid = 1'b0; st_clr = clr;
        end
    endtask

    task automatic pin(input int k, input int idx, input logic err, input logic [63:0] val,
                       input string name);
        n_checks++;
        if (idx >= exp_log[k].size()) begin
            n_fail++;
            $display("FAIL %s actual=missing required=0x%0h", name, val);
        end else if (exp_log[k][idx] !== {err, val}) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, exp_log[k][idx], {err, val});
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [1:0] sz;
        int         ad;
        st_valid = 0; st_we = 0; st_addr = 0; st_size = 0; st_uns = 0; st_wdata = 0; st_clr = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;

        // Word store then extracted loads (ops 0..3)
        issue(1, 8'h10, 2'b10, 0, 64'h8899AABB, 0);
        issue(0, 8'h13, 2'b00, 0, 64'h0, 0);
        issue(0, 8'h13, 2'b00, 1, 64'h0, 0);
        issue(0, 8'h12, 2'b01, 0, 64'h0, 0);
        // Byte-enable store (ops 4..6)
        issue(1, 8'h20, 2'b10, 0, 64'h11223344, 0);
        issue(1, 8'h21, 2'b00, 0, 64'hEE, 0);
        issue(0, 8'h20, 2'b10, 0, 64'h0, 0);
        // Misalignment leaves memory untouched (ops 7..10)
        issue(1, 8'h04, 2'b10, 0, 64'hCAFEF00D, 0);
        issue(1, 8'h05, 2'b01, 0, 64'hFFFF, 0);
        issue(0, 8'h06, 2'b10, 0, 64'h0, 0);
        issue(0, 8'h04, 2'b10, 0, 64'h0, 0);
        idle(3, 0);
        check("sticky_after_misalign", 64'(bus_a.err_sticky), 64'h1);
        idle(1, 1);
        idle(1, 0);
        check("sticky_cleared", 64'(bus_a.err_sticky), 64'h0);
        // err_clear concurrent with new errored responses (ops 11, 12)
        issue(0, 8'h02, 2'b10, 0, 64'h0, 0);
        issue(0, 8'h02, 2'b10, 0, 64'h0, 1);
        idle(1, 1);
        idle(3, 0);
        check("sticky_set_beats_clear_a", 64'(bus_a.err_sticky), 64'h1);
        check("sticky_set_beats_clear_b", 64'(bus_b.err_sticky), 64'h1);
        // Back-to-back store + 3 loads (ops 13..16)
        issue(1, 8'h30, 2'b10, 0, 64'h5A5A1234, 0);
        issue(0, 8'h30, 2'b10, 0, 64'h0, 0);
        issue(0, 8'h30, 2'b01, 1, 64'h0, 0);
        issue(0, 8'h31, 2'b00, 0, 64'h0, 0);
        // Doubleword accesses (ops 17..20)
        issue(1, 8'h08, 2'b11, 0, 64'h0123456789ABCDEF, 0);
        issue(0, 8'h0C, 2'b10, 0, 64'h0, 0);
        issue(0, 8'h0C, 2'b11, 0, 64'h0, 0);
        issue(0, 8'h08, 2'b11, 0, 64'h0, 0);
        idle(4, 0);

        pin(0, 1,  0, 64'hFFFFFF88, "pin_a_lb_signed");
        pin(0, 2,  0, 64'h00000088, "pin_a_lb_unsigned");
        pin(0, 3,  0, 64'hFFFF8899, "pin_a_lh_signed");
        pin(0, 6,  0, 64'h1122EE44, "pin_a_byte_enable");
        pin(0, 8,  1, 64'h0,        "pin_a_misaligned_store");
        pin(0, 9,  1, 64'h0,        "pin_a_misaligned_load");
        pin(0, 10, 0, 64'hCAFEF00D, "pin_a_memory_unchanged");
        pin(1, 14, 0, 64'h5A5A1234, "pin_b_raw_word");
        pin(1, 15, 0, 64'h00001234, "pin_b_half_unsigned");
        pin(1, 16, 0, 64'h00000012, "pin_b_byte_signed");
        pin(0, 17, 1, 64'h0,        "pin_a_double_illegal");
        pin(2, 1,  0, 64'hFFFFFFFFFFFFFF88, "pin_c_lb_signed");
        pin(2, 10, 0, 64'hFFFFFFFFCAFEF00D, "pin_c_word_signed");
        pin(2, 18, 0, 64'h0000000001234567, "pin_c_word_hi");
        pin(2, 19, 1, 64'h0,        "pin_c_double_misaligned");
        pin(2, 20, 0, 64'h0123456789ABCDEF, "pin_c_double_load");

        // Reset with responses in flight
        issue(0, 8'h30, 2'b10, 0, 64'h0, 0);
        issue(0, 8'h20, 2'b10, 0, 64'h0, 0);
        issue(1, 8'h05, 2'b01, 0, 64'h0, 0);
        @(negedge clk);
        st_valid = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_valid_b", 64'(bus_b.rsp_valid), 64'h0);
            check("reset_rdata_b", 64'(bus_b.rsp_rdata), 64'h0);
            check("reset_sticky_b", 64'(bus_b.err_sticky), 64'h0);
        end
        #2 reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_valid_a", 64'(bus_a.rsp_valid), 64'h0);
            check("post_reset_valid_b", 64'(bus_b.rsp_valid), 64'h0);
            check("post_reset_valid_c", 64'(bus_c.rsp_valid), 64'h0);
        end

        // Randomized traffic, mostly aligned, small address window
        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(0, 9) < 8) begin
                sz = 2'($urandom_range(0, 3));
                ad = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) ad = ad & ~((1 << sz) - 1);
                issue(1'($urandom_range(0, 9) < 4), 8'(ad), sz, 1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, 1'($urandom_range(0, 15) == 0));
            end else begin
                idle(1, 1'($urandom_range(0, 15) == 0));
            end
        end
        idle(4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/modulo_mem_dados_be.md
# modulo_mem_dados_be

Single-clock, byte-addressable data memory for the processor's load/store path. It replaces the word-only dual-clock RAM with a single request/response port that supports byte, halfword, word and, for 64-bit builds, doubleword accesses. Stores use per-byte write enables. Loads are sign- or zero-extended. Misaligned or illegal accesses are detected and reported. An optional output register stage trades one cycle of latency for timing.

## Interface
- DATA_WIDTH, 32, memory word width; legal values 32 or 64; NB = DATA_WIDTH/8 byte lanes, LB = log2(NB)
- ADDR_WIDTH, 15, byte-address width; depth = 2**(ADDR_WIDTH-LB) words
- OUT_REG, 0, 0 = response 1 cycle after request; 1 = extra output register, response 2 cycles after request

- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present this cycle; no backpressure, so one request is accepted every cycle it is high
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = doubleword (legal only when DATA_WIDTH = 64)
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  DATA_WIDTH  store data, right-aligned (the low 8/16/32/64 bits are used)
- err_clear  in  1  clears err_sticky
- rsp_valid  out  1  response strobe, one pulse per accepted request (loads and stores)
- rsp_rdata  out  DATA_WIDTH  load result, extended to DATA_WIDTH; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid: misaligned or illegal access
- err_sticky  out  1  set by any errored request; held until err_clear

## Operation
- Word index = req_addr[ADDR_WIDTH-1:LB]; byte offset = req_addr[LB-1:0].
- Alignment rules:
  - Half needs offset[0] = 0.
  - Word needs offset[1:0] = 0.
  - Double needs offset[2:0] = 0.
  - Size 11 with DATA_WIDTH = 32 is illegal.
- Errored request:
  - No memory write.
  - rsp_err = 1 and rsp_rdata = 0 in the response slot.
  - err_sticky is set.
- Store byte enables:
  - Byte: lane = offset.
  - Half: lanes offset and offset+1.
  - Word: 4 lanes starting at offset.
  - Double: all lanes.
  - Data is replicated or shifted to lane position; only enabled lanes are written.
- Load extraction:
  - Read the full word and shift right by offset*8.
  - Mask to the access size.
  - Fill the upper bits with the MSB of the accessed field when req_unsigned = 0, or with 0 when req_unsigned = 1.
- Load/store request attributes (size, offset, unsigned, err, we) are pipelined alongside the registered RAM read so that extraction is applied in the response cycle.
- Memory contents are not reset and are undefined until written.
- err_sticky update priority: set beats clear. If err_clear and an errored response occur in the same cycle, err_sticky stays 1.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_sticky = 0, and all pipeline valid bits = 0.
- Reset asserted mid-operation discards in-flight responses. No rsp_valid appears after reset deasserts unless a new request arrives.
- Request accepted at edge N:
  - OUT_REG = 0: rsp_valid is high in the cycle after edge N.
  - OUT_REG = 1: rsp_valid is high in the cycle after edge N+1.
- The store is committed at edge N.
- Fully pipelined throughput: one request per cycle, with responses in request order.
- Read-after-write, store at edge N and load to the same word at edge N+1: the load returns the post-store data.
- A request with req_valid = 0 produces no response. rsp_rdata holds 0 whenever rsp_valid = 0.
- err_sticky changes at the edge following the errored request's response slot, and err_clear takes effect at the next edge.

## Test plan
- Reset: hold reset_n = 0 mid-stream with requests in flight, then release. Required: all outputs 0 and no stray rsp_valid.
- Word store then loads, DATA_WIDTH = 32, OUT_REG = 0:
  - Store 0x8899AABB at 0x0010, then byte load at 0x0013 (signed), byte load at 0x0013 (unsigned) and half load at 0x0012 (signed).
  - Required: 0xFFFFFF88, 0x00000088 and 0xFFFF8899, each 1 cycle after its request.
- Byte-enable store: word 0x0020 holds 0x11223344; store byte 0xEE to 0x0021. Required: a word load at 0x0020 returns 0x1122EE44.
- Misalignment:
  - A half store at 0x0005 and a word load at 0x0006 each give rsp_err = 1 and rdata = 0, and err_sticky rises.
  - Memory is unchanged.
  - err_clear with a simultaneous new error leaves err_sticky = 1.
- Back-to-back with OUT_REG = 1: issue a store and 3 loads on consecutive cycles. Required: 4 rsp_valid pulses in order, each 2 cycles after its request, and the first load sees the store's data.
- DATA_WIDTH = 64:
  - Doubleword store 0x0123456789ABCDEF at 0x0008, then word load at 0x000C (signed). Required: 0x0000000001234567.
  - Size 11 at 0x000C. Required: rsp_err = 1.
